// File: rtl/genius_core_param.sv
`default_nettype none
// ==========================================================================
// genius_core_param : parametrised Simon/Genius game engine  |  Rev 1.0
// ==========================================================================
module genius_core_param #(
    parameter int          SYM_W          = 2,
    parameter int          MAX_LEVEL      = 16,
    parameter int          SHOW_CYCLES    = 25000000,
    parameter int          GAP_CYCLES     = 5000000,
    parameter int          TIMEOUT_CYCLES = 250000000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic [(2**SYM_W)-1:0]              btn,
    output logic                               show_valid,
    output logic [SYM_W-1:0]                   show_sym,
    output logic                               expect_input,
    output logic [$clog2(MAX_LEVEL+1)-1:0]     level,
    output logic [$clog2(MAX_LEVEL+1)-1:0]     step,
    output logic                               win,
    output logic                               lose,
    output logic                               busy
);

    localparam int N       = 2**SYM_W;
    localparam int LVL_W   = $clog2(MAX_LEVEL+1);
    localparam int AW      = $clog2(MAX_LEVEL);
    localparam int T_MAX   = (TIMEOUT_CYCLES > SHOW_CYCLES) ?
                             ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES) :
                             ((SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES);
    localparam int TIMER_W = $clog2(T_MAX);

    localparam logic [TIMER_W-1:0] SHOW_LAST = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TO_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LVL_W-1:0]   LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0]   LVL_MAX   = LVL_W'(MAX_LEVEL);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        APPEND     = 3'd1,
        SHOW_ON    = 3'd2,
        SHOW_GAP   = 3'd3,
        WAIT_INPUT = 3'd4,
        WIN        = 3'd5,
        LOSE       = 3'd6
    } state_t;

    state_t               state, state_n;
    logic [LVL_W-1:0]     level_n, step_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic [15:0]          lfsr, lfsr_n;
    logic [N-1:0]         btn_prev;
    logic [SYM_W-1:0]     show_sym_q;
    logic [SYM_W-1:0]     mem [0:MAX_LEVEL-1];
    logic                 mem_we;
    logic [SYM_W-1:0]     new_sym, exp_sym, rd_data;
    logic                 press, btn_ok, last_step;

    assign lfsr_n    = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign new_sym   = lfsr[SYM_W-1:0];
    assign exp_sym   = mem[step[AW-1:0]];
    assign press     = (btn != '0) && (btn_prev == '0);
    assign btn_ok    = (btn == (N'(1) << exp_sym));
    assign last_step = (step == level - LVL_ONE);

    // Bypass the symbol being appended so the first playback never reads a stale slot
    assign rd_data = (mem_we && (step_n == level)) ? new_sym : mem[step_n[AW-1:0]];

    always_comb begin
        state_n = state;
        level_n = level;
        step_n  = step;
        timer_n = timer;
        mem_we  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    level_n = '0;
                    step_n  = '0;
                    state_n = APPEND;
                end
            end
            APPEND: begin
                mem_we  = 1'b1;
                level_n = level + LVL_ONE;
                step_n  = '0;
                timer_n = '0;
                state_n = SHOW_ON;
            end
            SHOW_ON: begin
                if (timer == SHOW_LAST) begin
                    timer_n = '0;
                    state_n = SHOW_GAP;
                end else begin
                    timer_n = timer + TIMER_W'(1);
                end
            end
            SHOW_GAP: begin
                if (timer == GAP_LAST) begin
                    timer_n = '0;
                    if (last_step) begin
                        step_n  = '0;
                        state_n = WAIT_INPUT;
                    end else begin
                        step_n  = step + LVL_ONE;
                        state_n = SHOW_ON;
                    end
                end else begin
                    timer_n = timer + TIMER_W'(1);
                end
            end
            WAIT_INPUT: begin
                timer_n = timer + TIMER_W'(1);
                if (press) begin
                    if (!btn_ok) begin
                        state_n = LOSE;
                    end else if (!last_step) begin
                        step_n  = step + LVL_ONE;
                        timer_n = '0;
                    end else if (level == LVL_MAX) begin
                        state_n = WIN;
                    end else begin
                        state_n = APPEND;
                    end
                end else if (timer == TO_LAST) begin
                    state_n = LOSE;
                end
            end
            WIN, LOSE: state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            level      <= '0;
            step       <= '0;
            timer      <= '0;
            lfsr       <= LFSR_SEED;
            btn_prev   <= '0;
            show_sym_q <= '0;
        end else begin
            state      <= state_n;
            level      <= level_n;
            step       <= step_n;
            timer      <= timer_n;
            lfsr       <= lfsr_n;
            btn_prev   <= btn;
            show_sym_q <= rd_data;
        end
    end

    // Sequence storage is deliberately left uninitialised by reset
    always_ff @(posedge clock) begin
        if (reset && mem_we) begin
            mem[level[AW-1:0]] <= new_sym;
        end
    end

    assign show_valid   = (state == SHOW_ON);
    assign show_sym     = show_valid ? show_sym_q : '0;
    assign expect_input = (state == WAIT_INPUT);
    assign win          = (state == WIN);
    assign lose         = (state == LOSE);
    assign busy         = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_genius_core_param.sv
`default_nettype none
// Directed, randomised check of genius_core_param against a sequence-level game model.
module tb_genius_core_param;

    localparam int SYM_W = 2;
    localparam int MAXL  = 3;
    localparam int SHOWC = 3;
    localparam int GAPC  = 1;
    localparam int TOC   = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn   = 4'b0000;
    logic       show_valid, expect_input, win, lose, busy;
    logic [1:0] show_sym, level, step;

    genius_core_param #(
        .SYM_W(SYM_W), .MAX_LEVEL(MAXL), .SHOW_CYCLES(SHOWC),
        .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TOC), .LFSR_SEED(16'hACE1)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .btn(btn),
        .show_valid(show_valid), .show_sym(show_sym), .expect_input(expect_input),
        .level(level), .step(step), .win(win), .lose(lose), .busy(busy)
    );

    always #5 clock = ~clock;

    // Reference random source: the Galois polynomial x^16+x^14+x^13+x^11+1
    logic [15:0] m_lfsr;
    always @(posedge clock) begin
        if (!reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    int         checks   = 0;
    int         failures = 0;
    logic [1:0] seq [0:MAXL-1];
    int         mlev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called in the cycle where a new symbol is drawn
    task automatic do_append();
        check("append", {busy, show_valid, expect_input, level}, {1'b1, 1'b0, 1'b0, 2'(mlev)});
        seq[mlev] = m_lfsr[1:0];
        mlev++;
    endtask

    task automatic start_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        mlev  = 0;
        do_append();
    endtask

    // Playback of the whole stored sequence, ending in the first input cycle
    task automatic play();
        for (int s = 0; s < mlev; s++) begin
            for (int c = 0; c < SHOWC; c++) begin
                tick();
                check("show", {show_valid, show_sym, level, step},
                      {1'b1, seq[s], 2'(mlev), 2'(s)});
            end
            for (int g = 0; g < GAPC; g++) begin
                tick();
                check("gap", {busy, show_valid, show_sym, expect_input}, {1'b1, 1'b0, 2'b00, 1'b0});
            end
        end
        tick();
        check("wait_entry", {expect_input, step, show_valid}, {1'b1, 2'b00, 1'b0});
    endtask

    // Correct answers with random think time; leaves the bench in APPEND or WIN
    task automatic press_all();
        for (int s = 0; s < mlev; s++) begin
            repeat ($urandom_range(1, 3)) tick();
            btn = 4'b0001 << seq[s];
            tick();
            btn = 4'b0000;
            if (s < mlev - 1)
                check("step_adv", {expect_input, step, lose}, {1'b1, 2'(s + 1), 1'b0});
        end
    endtask

    initial begin
        // Reset and idle
        repeat (5) tick();
        check("reset", {busy, show_valid, show_sym, expect_input, win, lose, level, step}, 11'd0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle", {busy, show_valid, show_sym, expect_input, win, lose, level, step}, 11'd0);
        end

        // Full win; start kept high through the first playback must be ignored
        start = 1'b1;
        tick();
        mlev = 0;
        do_append();
        play();
        start = 1'b0;
        press_all(); do_append(); play();
        press_all(); do_append(); play();
        press_all();
        check("win_pulse", {win, lose, busy, level}, {1'b1, 1'b0, 1'b1, 2'd3});
        start = 1'b1;
        tick();
        check("win_idle", {win, busy, level}, {1'b0, 1'b0, 2'd3});
        tick();
        start = 1'b0;
        mlev  = 0;
        do_append();

        // Wrong one-hot press at level 2, step 0
        play(); press_all(); do_append(); play();
        btn = 4'b0001 << ((seq[0] + 2'($urandom_range(1, 3))) % 4);
        tick();
        btn = 4'b0000;
        check("wrong_lose", {lose, win, level}, {1'b1, 1'b0, 2'd2});
        tick();
        check("wrong_idle", {busy, lose, level}, {1'b0, 1'b0, 2'd2});

        // Multi-bit press
        start_game(); play(); press_all(); do_append(); play();
        btn = 4'b0011;
        tick();
        btn = 4'b0000;
        check("multi_lose", {lose, level}, {1'b1, 2'd2});
        tick();
        check("multi_idle", {busy, lose}, 2'b00);

        // Timeout after exactly TOC silent input cycles
        start_game(); play();
        for (int i = 0; i < TOC - 1; i++) begin
            tick();
            check("to_wait", {expect_input, lose}, 2'b10);
        end
        tick();
        check("to_lose", {lose, expect_input, level}, {1'b1, 1'b0, 2'd1});
        tick();
        check("to_idle", {busy, lose}, 2'b00);

        // Held button gives a single event
        start_game(); play(); press_all(); do_append(); play();
        btn = 4'b0001 << seq[0];
        tick();
        check("held_first", {step, lose}, {2'd1, 1'b0});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_hold", {expect_input, step, lose}, {1'b1, 2'd1, 1'b0});
        end
        btn = 4'b0000;
        tick();
        btn = 4'b0001 << seq[1];
        tick();
        btn = 4'b0000;
        do_append();

        // Reset during SHOW_ON
        tick();
        check("mid_show", show_valid, 1'b1);
        reset = 1'b0;
        tick();
        check("mid_reset", {busy, show_valid, win, lose, level, step}, 8'd0);
        reset = 1'b1;
        tick();
        check("post_reset", {busy, win, lose}, 3'b000);

        // Correct press on the last timeout cycle wins over the timeout
        start_game(); play();
        repeat (TOC - 1) tick();
        btn = 4'b0001 << seq[0];
        tick();
        btn = 4'b0000;
        check("prio", {lose, busy, expect_input, show_valid}, 4'b0100);
        do_append();
        play();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/genius_core_param.md
Name: genius_core_param

Overview:
- Parametrised Genius/Simon game engine; successor to the fixed 4-symbol, 16-level game FSM.
- Grows a stored random sequence by one symbol per level and plays it back with programmable on/gap timing.
- Checks player button presses with edge detection and an input timeout, and reports level, step, win and lose.
- Sits between board buttons (already synchronised) and the display/LED decoders; drives no 7-segment logic itself.

Parameters:
- SYM_W, 2, symbol width; number of buttons/colours N = 2**SYM_W.
- MAX_LEVEL, 16, sequence length needed to win (2..64); LVL_W = clog2(MAX_LEVEL+1).
- SHOW_CYCLES, 25000000, cycles each symbol is shown (>=1).
- GAP_CYCLES, 5000000, dark cycles between shown symbols (>=1).
- TIMEOUT_CYCLES, 250000000, max cycles waiting for a press (>=2).
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low
- start  in  1  level-sensitive game start; honoured only in IDLE
- btn  in  N  player buttons, active-high, pre-synchronised
- show_valid  out  1  high while a symbol is presented
- show_sym  out  SYM_W  symbol presented; 0 when show_valid=0
- expect_input  out  1  high in WAIT_INPUT
- level  out  LVL_W  current sequence length; holds after win/lose until next start
- step  out  LVL_W  index being shown or expected
- win  out  1  one-cycle pulse on completing MAX_LEVEL
- lose  out  1  one-cycle pulse on wrong press or timeout
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: reset and clock as decided (reset: synchronous, active-low; clock: clock). While reset=0: state=IDLE, level=0, step=0, timers=0, lfsr=LFSR_SEED, btn_prev=0, all outputs 0. Sequence memory is not cleared.
- LFSR: 16-bit Galois with taps 16,14,13,11. Advances every non-reset cycle in every state. New symbol = lfsr[SYM_W-1:0].
- Press event: a cycle where btn!=0 and btn_prev==0. btn_prev<=btn every cycle. A held button gives exactly one event. An event with more than one bit set is a wrong press.
- States:
  - IDLE: start=1 -> level<=0, step<=0, go APPEND.
  - APPEND (1 cycle): mem[level]<=new symbol; level<=level+1; step<=0; timer<=0; go SHOW_ON.
  - SHOW_ON: show_valid=1, show_sym=mem[step]. Stay SHOW_CYCLES cycles, then timer<=0 and go SHOW_GAP.
  - SHOW_GAP: outputs dark for GAP_CYCLES cycles. If step==level-1, then step<=0, timer<=0, go WAIT_INPUT; else step++ and go SHOW_ON.
  - WAIT_INPUT: timer increments each cycle.
    - Event with one-hot btn and index==mem[step]:
      - if step!=level-1: step++, timer<=0.
      - else if level==MAX_LEVEL: go WIN.
      - else: go APPEND.
    - Any other event: go LOSE.
    - No event and timer==TIMEOUT_CYCLES-1: go LOSE. An event in that same cycle takes priority over the timeout.
  - WIN / LOSE (1 cycle each): assert win or lose for that cycle, then go IDLE. level and step hold their values.
- Press events outside WAIT_INPUT are ignored, but btn_prev still updates.
- start while busy: ignored. start held high in IDLE after win/lose: a new game begins the next cycle.
- Reset mid-game: back to IDLE on the next edge; no win/lose pulse.
- Timing: SHOW_ON entered 1 cycle after APPEND. First WAIT_INPUT cycle follows the last gap cycle. One shown symbol occupies SHOW_CYCLES+GAP_CYCLES cycles.
- show_sym is registered and combinationally masked to 0 when not valid. Memory depth is MAX_LEVEL × SYM_W.

Test Plan (SYM_W=2, MAX_LEVEL=3, SHOW_CYCLES=3, GAP_CYCLES=1, TIMEOUT_CYCLES=10 unless noted):
- Reset and idle: hold reset=0 for 5 cycles, then release with start=0 -> all outputs 0, busy=0, state stays IDLE for 20 cycles.
- Show timing: pulse start -> APPEND, then show_valid=1 for exactly 3 cycles with level=1, step=0, then 1 dark cycle, then expect_input=1.
- Full win: press btn=1<<show_sym after each playback for levels 1,2,3 -> level reaches 3, one win pulse, busy=0, level stays 3.
- Wrong press: at level 2, step 0, press a non-matching one-hot button -> lose pulse 1 cycle later, IDLE, level=2 held; btn=4'b0011 at step 0 also gives lose.
- Timeout and held button: in WAIT_INPUT apply no press for 10 cycles -> lose. Separately, hold the correct button across two steps -> only step 0 advances, no further event until release and re-press.
- Reset mid-show and priority: drive reset=0 during SHOW_ON -> IDLE next edge, no pulse. Correct press in timer==9 cycle -> accepted, not lose.
